// File: rtl/nios_system_pio_in_edge.sv
// nios_system_pio_in_edge
// Avalon-MM input PIO for board switches/keys: two-flop synchroniser,
// per-bit edge capture (rising / falling / any), interrupt mask and a
// registered level irq to the Nios II.
// Optional per-bit debounce filter enabled with `define PIO_IN_DEBOUNCE_EN.
//
// Register map (word address):
//   0 DATA        RO   current (synchronised / debounced) level
//   1 reserved    reads 0, writes ignored
//   2 IRQMASK     RW
//   3 EDGECAPTURE R/W1C, a new edge wins over a same-cycle clear
module nios_system_pio_in_edge #(
    parameter int WIDTH           = 10,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // EDGE_TYPE values above 2 fold onto "any edge".
    localparam logic [1:0] EDGE_SEL = (EDGE_TYPE == 32'sd0) ? 2'd0 :
                                      (EDGE_TYPE == 32'sd1) ? 2'd1 : 2'd2;

    // Zero-extend a WIDTH-bit register onto the 32-bit read bus.
    function automatic logic [31:0] pad_to_bus(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r          = 32'd0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;
    logic [WIDTH-1:0] level_s;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] edge_r;
    logic [1:0]       warm_r;

    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] sel_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] edge_next_s;
    logic [WIDTH-1:0] mask_next_s;
    logic [1:0]       warm_next_s;
    logic             wr_en_s;
    logic [31:0]      rd_mux_s;
    logic             irq_next_s;

    // Only part of writedata lands in registers; fold the bus so every bit is consumed.
    logic             unused_wd_s;
    assign unused_wd_s = ^writedata;

    // Two-flop synchroniser on the asynchronous pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r <= {WIDTH{1'b0}};
            s2_r <= {WIDTH{1'b0}};
        end else begin
            s1_r <= in_port;
            s2_r <= s1_r;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r [WIDTH];
    logic [WIDTH-1:0] level_r;

    // Per-bit debounce: accept s2 only after it has differed from the level long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_r[i] == level_r[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (cnt_r[i] == CNT_MAX) begin
                    level_r[i] <= s2_r[i];
                    cnt_r[i]   <= {CNT_W{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    assign level_s = level_r;
`else
    assign level_s = s2_r;
`endif

    // Edge selection, W1C handling, mask update and the read mux.
    always_comb begin
        rise_s = level_s & ~prev_r;
        fall_s = ~level_s & prev_r;

        case (EDGE_SEL)
            2'd0:    sel_s = rise_s;
            2'd1:    sel_s = fall_s;
            default: sel_s = rise_s | fall_s;
        endcase

        wr_en_s = chipselect & ~write_n;

        if (wr_en_s && (address == 2'd3)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = {WIDTH{1'b0}};
        end

        // Until warm, prev is still being primed from reset zeros: capture nothing.
        if (warm_r == 2'd3) begin
            edge_next_s = (edge_r & ~clr_s) | sel_s;
            warm_next_s = 2'd3;
        end else begin
            edge_next_s = edge_r & ~clr_s;
            warm_next_s = warm_r + 2'd1;
        end

        if (wr_en_s && (address == 2'd2)) begin
            mask_next_s = writedata[WIDTH-1:0];
        end else begin
            mask_next_s = mask_r;
        end

        case (address)
            2'd0:    rd_mux_s = pad_to_bus(level_s);
            2'd2:    rd_mux_s = pad_to_bus(mask_r);
            2'd3:    rd_mux_s = pad_to_bus(edge_r);
            default: rd_mux_s = 32'd0;
        endcase

        irq_next_s = |(edge_r & mask_r);
    end

    // Register state plus the registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_r   <= 2'd0;
            prev_r   <= {WIDTH{1'b0}};
            mask_r   <= {WIDTH{1'b0}};
            edge_r   <= {WIDTH{1'b0}};
            readdata <= 32'd0;
            irq      <= 1'b0;
        end else begin
            warm_r   <= warm_next_s;
            prev_r   <= level_s;
            mask_r   <= mask_next_s;
            edge_r   <= edge_next_s;
            readdata <= rd_mux_s;
            irq      <= irq_next_s;
        end
    end

endmodule
